// File: rtl/csa_accum_ctrl.sv
// Multi-operand unsigned accumulator sequencer: operands are folded into carry-save
// sum/carry registers, then resolved to binary by iterated half-add before hand-off.
//
// state    | meaning
// IDLE     | waiting for start; out_data keeps the last result
// ACCUM    | in_ready high; one operand folded per in_valid cycle
// RESOLVE  | one half-add iteration per cycle until carry is zero
// DONE     | out_valid high; result held until out_ready
module csa_accum_ctrl #(
    parameter int W = 4,
    parameter int CW = 4,
    localparam int RW = W + CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] num_ops,
    output logic          busy,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [RW-1:0] out_data,
    input  logic          out_ready
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_RESOLVE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic [RW-1:0] s_q, s_d;
    logic [RW-1:0] c_q, c_d;
    logic [RW-1:0] result_q, result_d;
    logic [RW-1:0] x;

    assign x = {{CW{1'b0}}, in_data};

    // Handshake flags come from registered state only, so no input reaches them combinationally.
    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DONE);
    assign out_data  = result_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        s_d         = s_q;
        c_d         = c_q;
        result_d    = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_ops != '0) begin
                        remaining_d = num_ops;
                        s_d         = '0;
                        c_d         = '0;
                        state_d     = S_ACCUM;
                    end else begin
                        result_d = '0;
                        state_d  = S_DONE;
                    end
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    s_d         = s_q ^ c_q ^ x;
                    // MSB carry out is dropped; the full sum always fits in RW bits.
                    c_d         = ((s_q & c_q) | (s_q & x) | (c_q & x)) << 1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == {{(CW-1){1'b0}}, 1'b1}) begin
                        state_d = S_RESOLVE;
                    end
                end
            end
            S_RESOLVE: begin
                if (c_q == '0) begin
                    result_d = s_q;
                    state_d  = S_DONE;
                end else begin
                    s_d = s_q ^ c_q;
                    c_d = (s_q & c_q) << 1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            s_q         <= '0;
            c_q         <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            s_q         <= s_d;
            c_q         <= c_d;
            result_q    <= result_d;
        end
    end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Randomised bench for csa_accum_ctrl: every job's result is compared against the
// plain arithmetic sum of its operands, with handshake, stall and reset behaviour checked.
module tb_csa_accum_ctrl;

    localparam int W  = 4;
    localparam int CW = 4;
    localparam int RW = W + CW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] num_ops;
    logic          busy;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [RW-1:0] out_data;
    logic          out_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int ops_q[$];
    int lat;

    csa_accum_ctrl #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_ops   (num_ops),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one job from the operands in ops_q; lat counts cycles from the start edge to out_valid.
    task automatic run_job(input int gap_pct, input int hold_cycles, input bit poke,
                           output int lat_o);
        int n;
        int exp_sum;
        int idx;
        int budget;
        n = ops_q.size();
        exp_sum = 0;
        foreach (ops_q[i]) exp_sum += ops_q[i];

        start   = 1'b1;
        num_ops = CW'(n);
        tick();
        start = 1'b0;
        lat_o = 1;
        chk("busy_after_start", busy, 1);

        idx = 0;
        budget = 0;
        while (idx < n && budget < 400) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = in_valid ? W'(ops_q[idx]) : W'($urandom);
            if (poke) begin
                start   = 1'($urandom_range(1));
                num_ops = CW'($urandom);
            end
            if (in_valid && in_ready) idx++;
            tick();
            lat_o++;
            budget++;
        end
        chk("accum_count", idx, n);
        in_valid = 1'b0;
        in_data  = W'($urandom);

        budget = 0;
        while (!out_valid && budget < RW + 4) begin
            if (poke) start = 1'($urandom_range(1));
            tick();
            lat_o++;
            budget++;
        end
        chk("out_valid_rise", out_valid, 1);
        chk("in_ready_in_done", in_ready, 0);
        chk("result", out_data, exp_sum);

        for (int h = 0; h < hold_cycles; h++) begin
            if (poke) start = 1'($urandom_range(1));
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, exp_sum);
        end

        out_ready = 1'b1;
        start     = poke;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("valid_after_hs", out_valid, 0);
        chk("busy_after_hs", busy, 0);
        chk("data_kept_idle", out_data, exp_sum);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        num_ops   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        tick();

        // Basic job: 5+7+9 with out_valid six cycles after the start edge
        ops_q = '{5, 7, 9};
        run_job(0, 0, 1'b0, lat);
        chk("basic_lat", lat, 6);

        // Full-scale job: the largest possible sum must not be clipped
        ops_q.delete();
        for (int i = 0; i < 15; i++) ops_q.push_back(15);
        run_job(0, 0, 1'b0, lat);
        chk("max_lat_bound", 32'(lat <= 15 + RW + 2), 1);

        // Same operands gap-free then with gaps, back-pressure and ignored starts
        ops_q.delete();
        for (int i = 0; i < 9; i++) ops_q.push_back(int'($urandom_range(15)));
        run_job(0, 0, 1'b0, lat);
        run_job(40, 5, 1'b1, lat);

        // Zero-operand job followed immediately by a two-operand job
        ops_q.delete();
        run_job(0, 0, 1'b0, lat);
        chk("n0_lat", lat, 1);
        ops_q = '{15, 1};
        run_job(0, 0, 1'b0, lat);

        // Asynchronous reset in the middle of ACCUM after two of four operands
        start   = 1'b1;
        num_ops = CW'(4);
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = W'(9);
        tick();
        in_data  = W'(11);
        tick();
        in_valid = 1'b0;
        chk("midjob_in_ready", in_ready, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_in_ready", in_ready, 0);
        chk("async_out_valid", out_valid, 0);
        chk("async_out_data", out_data, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);
        ops_q = '{3};
        run_job(0, 0, 1'b0, lat);

        // Randomised jobs
        for (int j = 0; j < 20; j++) begin
            int n;
            n = int'($urandom_range(15));
            ops_q.delete();
            for (int i = 0; i < n; i++) ops_q.push_back(int'($urandom_range(15)));
            run_job(int'($urandom_range(50)), int'($urandom_range(4)), 1'b1, lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
